// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave):
// valid/ready request channel plus a response-valid load-data channel.
interface memory_access_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    dmem_req_valid;
  logic                    dmem_req_ready;
  logic                    dmem_req_write;
  logic [ADDRESS_BITS-1:0] dmem_req_addr;
  logic [DATA_WIDTH-1:0]   dmem_req_wdata;
  logic [3:0]              dmem_req_byte_en;
  logic                    dmem_resp_valid;
  logic [DATA_WIDTH-1:0]   dmem_resp_data;

  modport master (
    output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_byte_en,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );

  modport slave (
    input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_byte_en,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/memory_access_unit.sv
// RV32 memory stage: issues load/store requests on the data-memory bus, formats
// load data, stalls upstream while a transaction is open, registers writeback.
module memory_access_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ALU_result_memory,
  input  logic [DATA_WIDTH-1:0] store_data_memory,
  input  logic [4:0]            rd_memory,
  input  logic                  memRead_memory,
  input  logic                  memWrite_memory,
  input  logic                  regWrite_memory,
  input  logic [DATA_WIDTH-1:0] instruction_memory,
  memory_access_unit_if.master  dmem,
  output logic                  stall_memory,
  output logic                  wb_regWrite,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] wb_instruction,
  output logic                  misaligned_fault
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0]            OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0]            OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t r_state, w_next_state;

  logic                    r_req_valid;
  logic                    r_req_write;
  logic [ADDRESS_BITS-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0]   r_req_wdata;
  logic [3:0]              r_req_byte_en;
  logic [2:0]              r_funct3;
  logic [1:0]              r_off;
  logic [4:0]              r_rd;
  logic                    r_regwrite;
  logic [DATA_WIDTH-1:0]   r_instr;
  logic                    r_wb_regwrite;
  logic [4:0]              r_wb_rd;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic [DATA_WIDTH-1:0]   r_wb_instr;
  logic                    r_fault;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [1:0]            w_off;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_mem_op;
  logic                  w_misaligned;
  logic [3:0]            w_byte_en;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_load_byte;
  logic [15:0]           w_load_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_stall;

  assign w_opcode   = instruction_memory[6:0];
  assign w_funct3   = instruction_memory[14:12];
  assign w_off      = ALU_result_memory[1:0];
  assign w_is_load  = memRead_memory  && (w_opcode == OPCODE_LOAD);
  assign w_is_store = memWrite_memory && (w_opcode == OPCODE_STORE);
  assign w_mem_op   = w_is_load || w_is_store;

  // Access size comes from funct3[1:0]; loads reuse the lane logic but never enable bytes.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_misaligned = 1'b0;
    w_byte_en    = 4'b1111;
    w_wdata      = store_data_memory;
    unique case (w_funct3[1:0])
      2'b00: begin
        w_byte_en = 4'b0001 << w_off;
        w_wdata   = {4{store_data_memory[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_off[0];
        w_byte_en    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata      = {2{store_data_memory[15:0]}};
      end
      2'b10:   w_misaligned = (w_off != 2'b00);
      default: ;
    endcase
    if (!w_is_store) w_byte_en = 4'b0000;
  end

  always_comb begin
    w_load_byte = 8'h00;
    w_load_data = '0;
    unique case (r_off)
      2'd0: w_load_byte = dmem.dmem_resp_data[7:0];
      2'd1: w_load_byte = dmem.dmem_resp_data[15:8];
      2'd2: w_load_byte = dmem.dmem_resp_data[23:16];
      2'd3: w_load_byte = dmem.dmem_resp_data[31:24];
      default: ;
    endcase
    w_load_half = r_off[1] ? dmem.dmem_resp_data[31:16] : dmem.dmem_resp_data[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
      3'b001:  w_load_data = {{16{w_load_half[15]}}, w_load_half};
      3'b010:  w_load_data = dmem.dmem_resp_data;
      3'b100:  w_load_data = {24'h000000, w_load_byte};
      3'b101:  w_load_data = {16'h0000, w_load_half};
      default: w_load_data = '0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_mem_op && !w_misaligned) begin
        w_next_state = S_REQ;
        w_stall      = 1'b1;
      end
      S_REQ: begin
        // A store finishes on its ready cycle, so upstream may advance on that edge.
        w_stall = !(dmem.dmem_req_ready && r_req_write);
        if (dmem.dmem_req_ready) w_next_state = r_req_write ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        w_stall = !dmem.dmem_resp_valid;
        if (dmem.dmem_resp_valid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_valid   <= 1'b0;
      r_req_write   <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_req_byte_en <= 4'b0000;
      r_funct3      <= 3'b000;
      r_off         <= 2'b00;
      r_rd          <= 5'd0;
      r_regwrite    <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_data     <= '0;
      r_wb_instr    <= NOP_INSTR;
      r_fault       <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_mem_op) begin
            r_wb_regwrite <= regWrite_memory;
            r_wb_rd       <= rd_memory;
            r_wb_data     <= ALU_result_memory;
            r_wb_instr    <= instruction_memory;
          end else if (w_misaligned) begin
            r_fault       <= 1'b1;
            r_wb_regwrite <= 1'b0;
            r_wb_instr    <= NOP_INSTR;
          end else begin
            r_req_valid   <= 1'b1;
            r_req_write   <= w_is_store;
            r_req_addr    <= ALU_result_memory[ADDRESS_BITS-1:0];
            r_req_wdata   <= w_wdata;
            r_req_byte_en <= w_byte_en;
            r_funct3      <= w_funct3;
            r_off         <= w_off;
            r_rd          <= rd_memory;
            r_regwrite    <= regWrite_memory;
            r_instr       <= instruction_memory;
            r_wb_regwrite <= 1'b0;
            r_wb_instr    <= NOP_INSTR;
          end
        end
        S_REQ: if (dmem.dmem_req_ready) begin
          r_req_valid <= 1'b0;
          if (r_req_write) begin
            r_wb_regwrite <= 1'b0;
            r_wb_instr    <= r_instr;
          end
        end
        S_WAIT: if (dmem.dmem_resp_valid) begin
          r_wb_regwrite <= r_regwrite;
          r_wb_rd       <= r_rd;
          r_wb_data     <= w_load_data;
          r_wb_instr    <= r_instr;
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req_valid   = r_req_valid;
  assign dmem.dmem_req_write   = r_req_write;
  assign dmem.dmem_req_addr    = r_req_addr;
  assign dmem.dmem_req_wdata   = r_req_wdata;
  assign dmem.dmem_req_byte_en = r_req_byte_en;

  assign stall_memory     = w_stall;
  assign wb_regWrite      = r_wb_regwrite;
  assign wb_rd            = r_wb_rd;
  assign wb_data          = r_wb_data;
  assign wb_instruction   = r_wb_instr;
  assign misaligned_fault = r_fault;

endmodule
